div: RTL and testbench

Multi-cycle radix-2 restoring divider for the EX stage, serving DIV and DIVU. EX launches a division with a start request and stalls the pipeline while the divider runs. When the result is ready, EX drives {remainder, quotient} onto ex_hi/ex_lo with ex_whilo asserted into the EX/MEM register. The block accepts one operation at a time and has a fixed latency, except for divide-by-zero and annul.

---
 rtl/div_pkg.sv | 27 ++
 rtl/div.sv | 105 ++++++++++
 tb/tb_div.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared defines for the EX-stage divider: bus widths, FSM states,
// handshake levels and an operand magnitude helper.
package div_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    function automatic logic [RegBus-1:0] op_mag(
        input logic              sgn,
        input logic [RegBus-1:0] x
    );
        return (sgn && x[RegBus-1]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU; fixed 32-iteration latency,
// divide-by-zero short path, annul aborts the operation in flight.
module div
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_e              state_q;
    logic [5:0]              cnt_q;
    logic [DoubleRegBus:0]   work_q;
    logic [RegBus-1:0]       dvsr_q;
    logic                    sgn_q;
    logic                    a_neg_q;
    logic                    b_neg_q;
    logic                    ready_q;
    logic [DoubleRegBus-1:0] result_q;

    logic [RegBus:0]   diff;
    logic [RegBus-1:0] quo;
    logic [RegBus-1:0] rem;

    assign diff = {1'b0, work_q[63:32]} - {1'b0, dvsr_q};

    // Quotient sign follows both operands; remainder sign follows the dividend.
    assign quo = (sgn_q && (a_neg_q ^ b_neg_q)) ?
                 (~work_q[31:0] + 32'd1) : work_q[31:0];
    assign rem = (sgn_q && a_neg_q) ?
                 (~work_q[64:33] + 32'd1) : work_q[64:33];

    assign ready_o  = ready_q;
    assign result_o = result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DivFree;
            cnt_q    <= '0;
            work_q   <= '0;
            dvsr_q   <= '0;
            sgn_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            ready_q  <= DivResultNotReady;
            result_q <= '0;
        end else begin
            unique case (state_q)
                DivFree: begin
                    ready_q  <= DivResultNotReady;
                    result_q <= '0;
                    if (start_i == DivStart && !annul_i) begin
                        sgn_q   <= signed_div_i;
                        a_neg_q <= opdata1_i[31];
                        b_neg_q <= opdata2_i[31];
                        dvsr_q  <= op_mag(signed_div_i, opdata2_i);
                        work_q  <= {32'b0, op_mag(signed_div_i, opdata1_i), 1'b0};
                        cnt_q   <= '0;
                        state_q <= (opdata2_i == '0) ? DivByZero : DivOn;
                    end
                end
                DivByZero: begin
                    work_q   <= '0;
                    ready_q  <= DivResultReady;
                    result_q <= '0;
                    state_q  <= DivEnd;
                end
                DivOn: begin
                    if (annul_i) begin
                        cnt_q    <= '0;
                        ready_q  <= DivResultNotReady;
                        result_q <= '0;
                        state_q  <= DivFree;
                    end else if (cnt_q != 6'd32) begin
                        if (diff[32]) begin
                            work_q <= {work_q[63:0], 1'b0};
                        end else begin
                            work_q <= {diff[31:0], work_q[31:0], 1'b1};
                        end
                        cnt_q <= cnt_q + 6'd1;
                    end else begin
                        result_q <= {rem, quo};
                        ready_q  <= DivResultReady;
                        cnt_q    <= '0;
                        state_q  <= DivEnd;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        ready_q  <= DivResultNotReady;
                        result_q <= '0;
                        state_q  <= DivFree;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed-vector bench for the EX-stage divider.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_vec;
    int n_err;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for ready, check latency/result/hold/release.
    task automatic run_div(input string tag, input logic s,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int exp_lat,
                           input logic mut);
        int n;
        n = 0;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        while (n < 60) begin
            tick();
            n++;
            if (mut && n == 1) begin
                signed_div_i = ~s;
                opdata1_i    = 32'hFFFF_FFFF;
                opdata2_i    = 32'h0000_0003;
            end
            if (ready_o) break;
        end
        if (!ready_o) n = -1;
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_res"}, result_o, exp);
        tick();
        check({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
        check({tag, "_hold_res"}, result_o, exp);
        start_i = 1'b0;
        tick();
        check({tag, "_rel_rdy"}, 64'(ready_o), 64'd0);
        check({tag, "_rel_res"}, result_o, 64'd0);
    endtask

    initial begin
        int seen;
        n_vec        = 0;
        n_err        = 0;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        tick();
        tick();
        check("rst_rdy", 64'(ready_o), 64'd0);
        check("rst_res", result_o, 64'd0);
        rst = 1'b0;
        tick();

        run_div("u100_7", 1'b0, 32'd100, 32'd7,
                64'h00000002_0000000E, 34, 1'b0);
        run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
                64'hFFFFFFFF_FFFFFFFD, 34, 1'b0);
        run_div("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE,
                64'h00000001_FFFFFFFD, 34, 1'b0);
        run_div("dbz", 1'b0, 32'h1234_5678, 32'd0,
                64'd0, 2, 1'b0);
        run_div("s_min_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                64'h00000000_80000000, 34, 1'b0);
        run_div("u_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                64'h00000000_00000001, 34, 1'b0);
        run_div("opchg", 1'b0, 32'd100, 32'd7,
                64'h00000002_0000000E, 34, 1'b1);

        // Annul at iteration 10: request dropped together with the flush.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        seen         = 0;
        tick();
        for (int i = 1; i < 10; i++) begin
            if (ready_o) seen++;
            tick();
        end
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        check("annul_rdy", 64'(ready_o), 64'd0);
        check("annul_res", result_o, 64'd0);
        for (int i = 0; i < 40; i++) begin
            if (ready_o) seen++;
            tick();
        end
        check("annul_never_rdy", 64'(seen), 64'd0);
        run_div("u50_5", 1'b0, 32'd50, 32'd5,
                64'h00000000_0000000A, 34, 1'b0);

        // Reset mid-iteration.
        opdata1_i = 32'd77;
        opdata2_i = 32'd4;
        start_i   = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        rst     = 1'b1;
        start_i = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_on_rdy", 64'(ready_o), 64'd0);
        check("rst_on_res", result_o, 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o) seen++;
            tick();
        end
        check("rst_on_quiet", 64'(seen), 64'd0);

        // Reset while holding a finished result.
        opdata1_i = 32'd77;
        opdata2_i = 32'd4;
        start_i   = 1'b1;
        seen      = 0;
        while (!ready_o && seen < 60) begin
            tick();
            seen++;
        end
        check("end_res", result_o, 64'h00000001_00000013);
        rst     = 1'b1;
        start_i = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_end_rdy", 64'(ready_o), 64'd0);
        check("rst_end_res", result_o, 64'd0);

        run_div("post_rst", 1'b1, 32'hFFFF_FF9C, 32'd7,
                64'hFFFFFFFE_FFFFFFF2, 34, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
